sifive_datatap_capture: RTL and testbench
=========================================

Name: sifive_datatap_capture

Overview:
- Parametrised successor to the core's hierarchical data taps.
- Samples up to CH ready/valid tap channels, e.g. the dmem request channel, qualified by the tile's gated-clock-enable tap.
- Holds the sampled beats in a circular pre/post-trigger buffer inside the sifive_scope tree.
- After capture, drains the buffer in order over a ready/valid readout port to the scope backend.

Parameters:
- CH, 2, number of tapped channels (1..8)
- PAYLOAD_W, 32, payload bits per channel
- DEPTH, 16, buffer entries; power of two, at least 4
- TS_W, 16, timestamp width (used only with the optional feature)

Ports:
- clock  input  1  block clock
- reset_n  input  1  asynchronous active-low reset
- tap_valid  input  CH  per-channel valid tap
- tap_ready  input  CH  per-channel ready tap
- tap_payload  input  CH*PAYLOAD_W  per-channel payload; channel c is at bits [c*PAYLOAD_W +: PAYLOAD_W]
- tap_gate  input  1  gated-clock-enable tap; beats are ignored while it is 0
- ctl_arm  input  1  single-cycle pulse; arms capture
- ctl_clear  input  1  single-cycle pulse; aborts and empties the buffer
- ctl_trig_ch_mask  input  CH  channels eligible to trigger
- ctl_trig_match  input  PAYLOAD_W  trigger compare value
- ctl_trig_mask  input  PAYLOAD_W  compare bit enables
- ctl_post_cnt  input  $clog2(DEPTH)  number of beats to capture after the trigger beat
- status_state  output  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE
- status_wrapped  output  1  buffer has overwritten its oldest entry
- status_drops  output  8  saturating count of lost beats
- out_valid  output  1  readout valid
- out_ready  input  1  readout ready
- out_ch  output  max(1,$clog2(CH))  source channel of the entry
- out_payload  output  PAYLOAD_W  captured payload
- out_last  output  1  asserted on the final entry of the drain

Behaviour:
- Reset values (reset_n low, asynchronous): state IDLE, write pointer 0, read pointer 0, status_wrapped 0, status_drops 0, out_valid 0, out_last 0. Buffer contents are not reset.
- fire[c] = tap_valid[c] & tap_ready[c] & tap_gate.
- Capture happens only in ARMED and POST, at most one beat per cycle.
  - The lowest-index firing channel wins.
  - Each other firing channel in the same cycle adds 1 to status_drops, saturating at 255.
- A captured beat writes {channel, payload} at the write pointer, then the pointer increments modulo DEPTH.
- status_wrapped sets when the write pointer wraps from DEPTH-1 to 0.
- Trigger condition: the winning beat's channel is set in ctl_trig_ch_mask and (payload & ctl_trig_mask) == (ctl_trig_match & ctl_trig_mask).
- State transitions:
  - IDLE -> ARMED on ctl_arm. Pointers, wrap flag and drops are cleared on arm.
  - ARMED -> POST on a trigger beat. The trigger beat is captured, and the post counter loads ctl_post_cnt, sampled in that cycle.
  - ARMED -> DONE directly if ctl_post_cnt is 0 at the trigger.
  - POST: each captured beat decrements the post counter. The beat that brings it to 0 is captured, and the state moves to DONE at the next edge.
  - DONE: drain. The start index is the write pointer if wrapped, else 0. The entry count is DEPTH if wrapped, else the write pointer.
  - DONE -> IDLE after the out_last handshake.
- Readout:
  - out_valid is registered and asserts the cycle after entering DONE.
  - The payload is held stable until the out_valid & out_ready handshake; the next entry is presented in the following cycle, so full throughput is one beat per cycle.
- ctl_arm is ignored outside IDLE.
- ctl_clear wins over every other event in the same cycle, from any state. It forces IDLE, zeroes pointers, the wrap flag and drops, and drops out_valid in the next cycle.
- Because ctl_post_cnt <= DEPTH-1, the trigger beat is always retained.
- reset_n asserted mid-capture or mid-drain returns to the reset state immediately, with no partial readout.

Optional Feature:
- Macro: SIFIVE_DATATAP_CAPTURE_TIMESTAMP_EN.
- Enabled:
  - A free-running TS_W-bit cycle counter, reset to 0, wraps naturally.
  - It is stored with each captured beat.
  - Extra output port out_ts (TS_W bits) presents the stored value alongside out_payload.
- Disabled: no counter, no storage, and no out_ts port.

Test Plan:
- Arm, CH0 fires 5 beats with payloads 1..5, trigger match 3/mask FFFFFFFF, post_cnt 2 -> DONE after beat 5; drain yields 1,2,3,4,5 with out_last on 5; status_wrapped 0.
- DEPTH=16, 20 non-matching beats (payloads 0..19), then trigger 0xAA with post_cnt 0 -> wrapped 1; drain yields 16 entries, 5..19 then 0xAA.
- CH0 and CH1 fire together 300 times while ARMED -> only CH0 captured; status_drops saturates at 255.
- tap_gate=0 with valid & ready high on a matching beat -> no capture, state stays ARMED.
- ctl_clear in POST with out_ready low -> IDLE next cycle, out_valid 0; ctl_arm in the same cycle as ctl_clear is ignored.
- Drain with out_ready toggling 1,0,1,0 -> out_payload stable while stalled; no entry lost or duplicated; reset_n pulsed mid-drain -> all outputs return to reset values.

Source files
------------

// File: rtl/sifive_datatap_capture.sv
// Ready/valid tap capture into a circular pre/post-trigger buffer, drained in order over a readout port.
// Optional per-beat timestamps: define SIFIVE_DATATAP_CAPTURE_TIMESTAMP_EN to add the counter and out_ts.
module sifive_datatap_capture #(
    parameter int CH        = 2,
    parameter int PAYLOAD_W = 32,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [CH-1:0]                          tap_valid,
    input  logic [CH-1:0]                          tap_ready,
    input  logic [CH*PAYLOAD_W-1:0]                tap_payload,
    input  logic                                   tap_gate,
    input  logic                                   ctl_arm,
    input  logic                                   ctl_clear,
    input  logic [CH-1:0]                          ctl_trig_ch_mask,
    input  logic [PAYLOAD_W-1:0]                   ctl_trig_match,
    input  logic [PAYLOAD_W-1:0]                   ctl_trig_mask,
    input  logic [$clog2(DEPTH)-1:0]               ctl_post_cnt,
    output logic [1:0]                             status_state,
    output logic                                   status_wrapped,
    output logic [7:0]                             status_drops,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
    output logic [PAYLOAD_W-1:0]                   out_payload,
`ifdef SIFIVE_DATATAP_CAPTURE_TIMESTAMP_EN
    output logic [TS_W-1:0]                        out_ts,
`endif
    output logic                                   out_last
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    if (CH < 1 || CH > 8 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_cfg
        $error("sifive_datatap_capture: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   post_cnt;
    logic [AW:0]     remain;

    logic [CH-1:0]        fire;
    logic [3:0]           n_fire;
    logic [CW-1:0]        win_ch;
    logic [PAYLOAD_W-1:0] win_pl;
    logic                 any_fire;
    logic                 capture;
    logic                 trig;
    logic [8:0]           drops_sum;
    logic [7:0]           drops_nxt;

    logic [AW-1:0]   drain_start;
    logic [AW:0]     drain_cnt;
    logic            drain_load;
    logic            drain_adv;
    logic [AW-1:0]   rd_sel;

    logic [CW-1:0]        mem_ch [DEPTH];
    logic [PAYLOAD_W-1:0] mem_pl [DEPTH];

    assign status_state = state;

    // Descending scan leaves the lowest-index firing channel as the winner.
    always_comb begin
        fire   = tap_valid & tap_ready & {CH{tap_gate}};
        win_ch = '0;
        n_fire = '0;
        for (int c = CH - 1; c >= 0; c--) begin
            if (fire[c]) win_ch = CW'(c);
        end
        for (int c = 0; c < CH; c++) begin
            n_fire = n_fire + 4'(fire[c]);
        end
    end

    assign any_fire  = |fire;
    assign win_pl    = tap_payload[win_ch*PAYLOAD_W +: PAYLOAD_W];
    assign capture   = any_fire & ((state == S_ARMED) | (state == S_POST));
    assign trig      = ctl_trig_ch_mask[win_ch] &
                       ((win_pl & ctl_trig_mask) == (ctl_trig_match & ctl_trig_mask));
    assign drops_sum = {1'b0, status_drops} + 9'(n_fire) - 9'd1;
    assign drops_nxt = drops_sum[8] ? 8'hFF : drops_sum[7:0];

    // Once wrapped, the oldest surviving entry sits at the write pointer.
    assign drain_start = status_wrapped ? wr_ptr : '0;
    assign drain_cnt   = status_wrapped ? {1'b1, {AW{1'b0}}} : {1'b0, wr_ptr};
    assign drain_load  = (state == S_DONE) & ~out_valid & ~ctl_clear;
    assign drain_adv   = (state == S_DONE) & out_valid & out_ready & ~out_last & ~ctl_clear;
    assign rd_sel      = drain_load ? drain_start : rd_ptr + 1'b1;

    always_ff @(posedge clock) begin
        if (capture) begin
            mem_ch[wr_ptr] <= win_ch;
            mem_pl[wr_ptr] <= win_pl;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            post_cnt       <= '0;
            remain         <= '0;
            status_wrapped <= 1'b0;
            status_drops   <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
        end else if (ctl_clear) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            post_cnt       <= '0;
            remain         <= '0;
            status_wrapped <= 1'b0;
            status_drops   <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctl_arm) begin
                        state          <= S_ARMED;
                        wr_ptr         <= '0;
                        rd_ptr         <= '0;
                        status_wrapped <= 1'b0;
                        status_drops   <= '0;
                    end
                end
                S_ARMED, S_POST: begin
                    if (capture) begin
                        status_drops <= drops_nxt;
                        wr_ptr       <= wr_ptr + 1'b1;
                        if (wr_ptr == AW'(DEPTH - 1)) status_wrapped <= 1'b1;
                        if (state == S_ARMED) begin
                            if (trig) begin
                                post_cnt <= ctl_post_cnt;
                                state    <= (ctl_post_cnt == '0) ? S_DONE : S_POST;
                            end
                        end else begin
                            post_cnt <= post_cnt - 1'b1;
                            if (post_cnt == AW'(1)) state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (drain_load) begin
                        rd_ptr    <= rd_sel;
                        remain    <= drain_cnt;
                        out_valid <= 1'b1;
                        out_last  <= (drain_cnt == (AW+1)'(1));
                    end else if (drain_adv) begin
                        rd_ptr   <= rd_sel;
                        remain   <= remain - 1'b1;
                        out_last <= (remain == (AW+1)'(2));
                    end else if (out_valid && out_ready && out_last) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output entry is registered so it stays put while the backend stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_ch      <= '0;
            out_payload <= '0;
        end else if (drain_load || drain_adv) begin
            out_ch      <= mem_ch[rd_sel];
            out_payload <= mem_pl[rd_sel];
        end
    end

`ifdef SIFIVE_DATATAP_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ts_cnt <= '0;
        else          ts_cnt <= ts_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (capture) mem_ts[wr_ptr] <= ts_cnt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                     out_ts <= '0;
        else if (drain_load || drain_adv) out_ts <= mem_ts[rd_sel];
    end
`endif

endmodule

// File: tb/tb_sifive_datatap_capture.sv
// Bench for sifive_datatap_capture: queue-based reference model checked every cycle plus directed literal checks.
module tb_sifive_datatap_capture;

    localparam int CH    = 2;
    localparam int PW    = 32;
    localparam int DEPTH = 16;
    localparam int TS_W  = 16;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic [CH-1:0]   tap_valid = '0;
    logic [CH-1:0]   tap_ready = '0;
    logic [CH*PW-1:0] tap_payload = '0;
    logic            tap_gate = 1'b1;
    logic            ctl_arm = 1'b0;
    logic            ctl_clear = 1'b0;
    logic [CH-1:0]   ctl_trig_ch_mask = '0;
    logic [PW-1:0]   ctl_trig_match = '0;
    logic [PW-1:0]   ctl_trig_mask = '0;
    logic [3:0]      ctl_post_cnt = '0;
    logic [1:0]      status_state;
    logic            status_wrapped;
    logic [7:0]      status_drops;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [0:0]      out_ch;
    logic [PW-1:0]   out_payload;
    logic            out_last;
`ifdef SIFIVE_DATATAP_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] out_ts;
`endif

    sifive_datatap_capture #(.CH(CH), .PAYLOAD_W(PW), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_payload(tap_payload), .tap_gate(tap_gate),
        .ctl_arm(ctl_arm), .ctl_clear(ctl_clear), .ctl_trig_ch_mask(ctl_trig_ch_mask),
        .ctl_trig_match(ctl_trig_match), .ctl_trig_mask(ctl_trig_mask), .ctl_post_cnt(ctl_post_cnt),
        .status_state(status_state), .status_wrapped(status_wrapped), .status_drops(status_drops),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_payload(out_payload),
`ifdef SIFIVE_DATATAP_CAPTURE_TIMESTAMP_EN
        .out_ts(out_ts),
`endif
        .out_last(out_last)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is just the last DEPTH captured beats, in capture order.
    typedef struct { int ch; logic [PW-1:0] pl; logic last; } ent_t;
    ent_t m_buf[$];
    ent_t m_drain[$];
    ent_t got[$];
    ent_t e;
    int   m_state = 0, m_drops = 0, m_post = 0, m_nwr = 0;
    bit   m_vld = 0;
    int   nf, win;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_drops = 0; m_post = 0; m_nwr = 0; m_vld = 0;
            m_buf.delete(); m_drain.delete();
        end else begin
            nf = 0; win = 0;
            for (int c = CH - 1; c >= 0; c--)
                if (tap_valid[c] && tap_ready[c] && tap_gate) begin nf++; win = c; end
            if (ctl_clear) begin
                m_state = 0; m_drops = 0; m_nwr = 0; m_vld = 0;
                m_buf.delete(); m_drain.delete();
            end else begin
                case (m_state)
                    0: if (ctl_arm) begin m_state = 1; m_buf.delete(); m_nwr = 0; m_drops = 0; end
                    1, 2: if (nf > 0) begin
                        m_drops = (m_drops + nf - 1 > 255) ? 255 : m_drops + nf - 1;
                        e.ch = win; e.pl = tap_payload[win*PW +: PW]; e.last = 1'b0;
                        m_buf.push_back(e);
                        m_nwr++;
                        if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
                        if (m_state == 1) begin
                            if (ctl_trig_ch_mask[win] && ((e.pl & ctl_trig_mask) == (ctl_trig_match & ctl_trig_mask))) begin
                                if (ctl_post_cnt == 0) m_state = 3;
                                else begin m_post = ctl_post_cnt; m_state = 2; end
                            end
                        end else begin
                            m_post--;
                            if (m_post == 0) m_state = 3;
                        end
                    end
                    default: begin
                        if (!m_vld) begin m_vld = 1; m_drain = m_buf; end
                        else if (out_ready) begin
                            void'(m_drain.pop_front());
                            if (m_drain.size() == 0) begin m_vld = 0; m_state = 0; end
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("state", 64'(status_state), 64'(m_state));
            chk("wrapped", 64'(status_wrapped), 64'(m_nwr >= DEPTH));
            chk("drops", 64'(status_drops), 64'(m_drops));
            chk("out_valid", 64'(out_valid), 64'(m_vld));
            if (m_vld && m_drain.size() > 0) begin
                chk("out_ch", 64'(out_ch), 64'(m_drain[0].ch));
                chk("out_payload", 64'(out_payload), 64'(m_drain[0].pl));
                chk("out_last", 64'(out_last), 64'(m_drain.size() == 1));
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            ent_t g;
            g.ch = int'(out_ch); g.pl = out_payload; g.last = out_last;
            got.push_back(g);
        end
    end

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic beat(input logic [CH-1:0] m, input logic [PW-1:0] p0, input logic [PW-1:0] p1);
        tap_valid = m; tap_ready = m; tap_payload = {p1, p0};
        cyc();
        tap_valid = '0; tap_ready = '0;
    endtask

    task automatic arm();
        ctl_arm = 1'b1; cyc(); ctl_arm = 1'b0;
    endtask

    task automatic trig_cfg(input logic [CH-1:0] chm, input logic [PW-1:0] mt, input logic [PW-1:0] mk, input logic [3:0] pc);
        ctl_trig_ch_mask = chm; ctl_trig_match = mt; ctl_trig_mask = mk; ctl_post_cnt = pc;
    endtask

    task automatic drain_all();
        bit done;
        done = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            cyc();
            if (status_state == 2'd0) done = 1;
        end
        chk("drain_timeout_state", 64'(status_state), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        cyc(); cyc();
        chk("rst_state", 64'(status_state), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_wrapped", 64'(status_wrapped), 64'd0);
        chk("rst_drops", 64'(status_drops), 64'd0);
        reset_n = 1'b1;
        cyc();

        // 1: payloads 1..5, trigger on 3 with two post beats
        trig_cfg(2'b01, 32'd3, 32'hFFFF_FFFF, 4'd2);
        arm();
        for (int i = 1; i <= 5; i++) beat(2'b01, 32'(i), 32'h0);
        chk("t1_state_done", 64'(status_state), 64'd3);
        got.delete();
        drain_all();
        chk("t1_count", 64'(got.size()), 64'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("t1_payload", 64'(got[i].pl), 64'(i + 1));
        if (got.size() == 5) chk("t1_last", 64'(got[4].last), 64'd1);
        chk("t1_wrapped", 64'(status_wrapped), 64'd0);

        // 2: wrap, then a zero-post trigger
        trig_cfg(2'b01, 32'hAA, 32'hFF, 4'd0);
        arm();
        for (int i = 0; i < 20; i++) beat(2'b01, 32'(i), 32'h0);
        beat(2'b01, 32'hAA, 32'h0);
        got.delete();
        drain_all();
        chk("t2_count", 64'(got.size()), 64'd16);
        if (got.size() == 16) begin
            chk("t2_first", 64'(got[0].pl), 64'd5);
            chk("t2_fifteenth", 64'(got[14].pl), 64'd19);
            chk("t2_trigger_last", 64'(got[15].pl), 64'hAA);
            chk("t2_last_flag", 64'(got[15].last), 64'd1);
        end
        chk("t2_wrapped", 64'(status_wrapped), 64'd1);

        // 3: simultaneous firing, drops saturate, only CH0 kept
        trig_cfg(2'b00, 32'h0, 32'h0, 4'd0);
        arm();
        for (int i = 0; i < 300; i++) beat(2'b11, 32'(i), 32'h8000_0000 | 32'(i));
        chk("t3_drops_sat", 64'(status_drops), 64'd255);
        chk("t3_state_armed", 64'(status_state), 64'd1);
        trig_cfg(2'b01, 32'h0, 32'h0, 4'd0);
        beat(2'b01, 32'hBEEF, 32'h0);
        got.delete();
        drain_all();
        chk("t3_count", 64'(got.size()), 64'd16);
        for (int i = 0; i < got.size(); i++) chk("t3_ch0_only", 64'(got[i].ch), 64'd0);
        if (got.size() == 16) begin
            chk("t3_first", 64'(got[0].pl), 64'd285);
            chk("t3_trigger", 64'(got[15].pl), 64'hBEEF);
        end

        // 4: gate low masks a matching beat
        trig_cfg(2'b01, 32'h55, 32'hFFFF_FFFF, 4'd0);
        arm();
        tap_gate = 1'b0;
        beat(2'b01, 32'h55, 32'h0);
        beat(2'b11, 32'h55, 32'h55);
        chk("t4_state_armed", 64'(status_state), 64'd1);
        chk("t4_drops", 64'(status_drops), 64'd0);
        tap_gate = 1'b1;
        ctl_clear = 1'b1; cyc(); ctl_clear = 1'b0;

        // 5: clear in POST beats a same-cycle arm
        trig_cfg(2'b01, 32'h7, 32'hFFFF_FFFF, 4'd3);
        arm();
        beat(2'b01, 32'h7, 32'h0);
        beat(2'b01, 32'h8, 32'h0);
        chk("t5_state_post", 64'(status_state), 64'd2);
        out_ready = 1'b0;
        ctl_clear = 1'b1; ctl_arm = 1'b1;
        cyc();
        ctl_clear = 1'b0; ctl_arm = 1'b0;
        chk("t5_state_idle", 64'(status_state), 64'd0);
        chk("t5_valid", 64'(out_valid), 64'd0);
        cyc();
        chk("t5_still_idle", 64'(status_state), 64'd0);

        // 6: stalled drain, then reset mid-drain
        trig_cfg(2'b01, 32'h105, 32'hFFFF_FFFF, 4'd0);
        arm();
        for (int i = 0; i < 6; i++) beat(2'b01, 32'h100 + 32'(i), 32'h0);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                if (out_valid) seen = 1;
                else cyc();
            end
            chk("t6_valid_seen", 64'(out_valid), 64'd1);
        end
        got.delete();
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            cyc();
        end
        out_ready = 1'b0;
        chk("t6_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t6_payload", 64'(got[i].pl), 64'h100 + 64'(i));
        chk("t6_still_draining", 64'(status_state), 64'd3);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_state", 64'(status_state), 64'd0);
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_last", 64'(out_last), 64'd0);
        chk("t6_rst_wrapped", 64'(status_wrapped), 64'd0);
        chk("t6_rst_drops", 64'(status_drops), 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc(); cyc();
        chk("t6_post_rst_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
